// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one multi-cycle, single-port memory between an instruction-fetch
// requester (i_*) and a load/store requester (d_*). Each side has at most one
// request outstanding and gets a one-cycle done pulse back. Data wins ties
// unless fetch has been passed over STARVE_LIMIT times in a row. A WAIT
// timer forces completion with an error flag if the memory never answers.
//
// Ports
//   clk, reset                 rising-edge clock, async active-low reset
//   i_req, i_addr              fetch request (held until i_done)
//   i_rdata, i_done, i_err     fetch read data / completion pulse / timeout flag
//   d_req, d_wen, d_addr,
//   d_wdata, d_be              data request (held until d_done)
//   d_rdata, d_done, d_err     data read data / completion pulse / timeout flag
//   m_valid, m_wen, m_addr,
//   m_wdata, m_be              one-cycle command strobe and held command fields
//   m_rdata, m_done            memory read data and completion pulse
//   busy                       high whenever not IDLE
//   owner                      0 = fetch, 1 = data (current or last grant)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | arbitrate; latch the winner's command and go to ISSUE
// ISSUE | m_valid high for this single cycle, WAIT timer cleared
// WAIT  | wait for m_done or for the timer to reach TIMEOUT-1
// RESP  | owner's done (and err) high for one cycle, then IDLE
//
// Every output is a flop; done/err/m_valid are set on the transition into
// the state in which they are visible.

module mem_arbiter #(
   parameter int ADDR_BITS    = 10,
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_req,
   input  logic [ADDR_BITS-1:0] i_addr,
   output logic [31:0]          i_rdata,
   output logic                 i_done,
   output logic                 i_err,
   input  logic                 d_req,
   input  logic                 d_wen,
   input  logic [ADDR_BITS-1:0] d_addr,
   input  logic [31:0]          d_wdata,
   input  logic [3:0]           d_be,
   output logic [31:0]          d_rdata,
   output logic                 d_done,
   output logic                 d_err,
   output logic                 m_valid,
   output logic                 m_wen,
   output logic [ADDR_BITS-1:0] m_addr,
   output logic [31:0]          m_wdata,
   output logic [3:0]           m_be,
   input  logic [31:0]          m_rdata,
   input  logic                 m_done,
   output logic                 busy,
   output logic                 owner
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   localparam logic [3:0] LP_STARVE  = 4'(STARVE_LIMIT);
   localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT - 1);

   state_t               r_state;
   logic [3:0]           r_streak;
   logic [7:0]           r_timer;
   logic                 r_owner;
   logic                 r_busy;
   logic                 r_m_valid;
   logic                 r_m_wen;
   logic [ADDR_BITS-1:0] r_m_addr;
   logic [31:0]          r_m_wdata;
   logic [3:0]           r_m_be;
   logic [31:0]          r_i_rdata;
   logic [31:0]          r_d_rdata;
   logic                 r_i_done;
   logic                 r_i_err;
   logic                 r_d_done;
   logic                 r_d_err;

   logic                 w_grant_d;
   logic                 w_grant_i;
   logic                 w_timeout;

   // Data loses only when fetch is waiting and has already been passed over
   // STARVE_LIMIT consecutive times.
   assign w_grant_d = d_req && !(i_req && (r_streak == LP_STARVE));
   assign w_grant_i = !w_grant_d && i_req;
   assign w_timeout = (r_timer == LP_TO_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_IDLE;
         r_streak  <= 4'd0;
         r_timer   <= 8'd0;
         r_owner   <= 1'b0;
         r_busy    <= 1'b0;
         r_m_valid <= 1'b0;
         r_m_wen   <= 1'b0;
         r_m_addr  <= '0;
         r_m_wdata <= 32'd0;
         r_m_be    <= 4'd0;
         r_i_rdata <= 32'd0;
         r_d_rdata <= 32'd0;
         r_i_done  <= 1'b0;
         r_i_err   <= 1'b0;
         r_d_done  <= 1'b0;
         r_d_err   <= 1'b0;
      end else begin
         r_m_valid <= 1'b0;
         r_i_done  <= 1'b0;
         r_i_err   <= 1'b0;
         r_d_done  <= 1'b0;
         r_d_err   <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (!i_req) begin
                  r_streak <= 4'd0;
               end else if (w_grant_d) begin
                  if (r_streak != LP_STARVE) begin
                     r_streak <= r_streak + 4'd1;
                  end
               end else begin
                  r_streak <= 4'd0;
               end

               if (w_grant_d || w_grant_i) begin
                  r_owner   <= w_grant_d;
                  r_m_wen   <= w_grant_d & d_wen;
                  r_m_addr  <= w_grant_d ? d_addr : i_addr;
                  r_m_wdata <= d_wdata;
                  r_m_be    <= w_grant_d ? d_be : 4'hF;
                  r_m_valid <= 1'b1;
                  r_busy    <= 1'b1;
                  r_state   <= ST_ISSUE;
               end
            end

            ST_ISSUE: begin
               r_timer <= 8'd0;
               r_state <= ST_WAIT;
            end

            ST_WAIT: begin
               r_timer <= r_timer + 8'd1;
               if (m_done) begin
                  if (!r_owner) begin
                     r_i_rdata <= m_rdata;
                  end else if (!r_m_wen) begin
                     r_d_rdata <= m_rdata;
                  end
                  r_i_done <= ~r_owner;
                  r_d_done <= r_owner;
                  r_state  <= ST_RESP;
               end else if (w_timeout) begin
                  if (!r_owner) begin
                     r_i_rdata <= 32'd0;
                  end else begin
                     r_d_rdata <= 32'd0;
                  end
                  r_i_done <= ~r_owner;
                  r_i_err  <= ~r_owner;
                  r_d_done <= r_owner;
                  r_d_err  <= r_owner;
                  r_state  <= ST_RESP;
               end
            end

            ST_RESP: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end

            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign i_rdata = r_i_rdata;
   assign i_done  = r_i_done;
   assign i_err   = r_i_err;
   assign d_rdata = r_d_rdata;
   assign d_done  = r_d_done;
   assign d_err   = r_d_err;
   assign m_valid = r_m_valid;
   assign m_wen   = r_m_wen;
   assign m_addr  = r_m_addr;
   assign m_wdata = r_m_wdata;
   assign m_be    = r_m_be;
   assign busy    = r_busy;
   assign owner   = r_owner;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one multi-cycle, single-port unified memory between the instruction-fetch path and the load/store path. Each side issues one outstanding request and receives a one-cycle completion pulse. Data requests have priority, and a bounded-starvation counter guarantees fetch progress. A timeout recovers from a memory that never answers.

## Interface
Parameters:
- ADDR_BITS, 10, word-address width (shared by both requesters and the memory).
- STARVE_LIMIT, 4, maximum consecutive data grants while a fetch is pending; legal range 1..15.
- TIMEOUT, 32, maximum cycles spent in WAIT before forced completion; legal range 2..255.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; held high until i_done.
- i_addr  in  ADDR_BITS  fetch word address.
- i_rdata  out  32  fetch data; valid in the i_done cycle and held until the next i_done.
- i_done  out  1  one-cycle fetch completion pulse.
- i_err  out  1  high with i_done when the fetch timed out.
- d_req  in  1  data request; held high until d_done.
- d_wen  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_BITS  data word address.
- d_wdata  in  32  write data.
- d_be  in  4  byte enables, bit n selects byte n.
- d_rdata  out  32  read data; valid in the d_done cycle and held until the next d_done.
- d_done  out  1  one-cycle data completion pulse (reads and writes).
- d_err  out  1  high with d_done on timeout.
- m_valid  out  1  one-cycle command strobe to memory.
- m_wen, m_addr, m_wdata, m_be  out  1/ADDR_BITS/32/4  command fields; stable from m_valid until the next grant.
- m_rdata  in  32  memory read data, valid when m_done=1.
- m_done  in  1  one-cycle memory completion pulse.
- busy  out  1  high in every state except IDLE.
- owner  out  1  0 = fetch, 1 = data; the latched owner of the current or last transaction.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- **IDLE**, evaluated each cycle:
  - If d_req && !(i_req && streak==STARVE_LIMIT), grant data.
  - Else if i_req, grant fetch.
  - On a grant, latch owner, wen (forced to 0 for a fetch), addr, wdata, and be (forced to 4'hF for a fetch), then go to ISSUE.
  - With no request, remain in IDLE.
- **streak** (4-bit):
  - Increments on a data grant while i_req=1.
  - Clears on a fetch grant.
  - Clears at any IDLE evaluation where i_req=0.
  - Saturates at STARVE_LIMIT.
- **ISSUE**: m_valid=1 for exactly this cycle; timer cleared; go to WAIT.
- **WAIT**: timer increments each cycle.
  - If m_done=1: capture m_rdata into the owner's rdata register, clear err, go to RESP.
  - Else if timer==TIMEOUT-1: owner's rdata := 0, err := 1, go to RESP.
  - m_done has priority over timeout in the same cycle.
- **RESP**: assert the owner's done (and err if set) for one cycle; go to IDLE.
- **Write completion**: d_rdata is not updated on writes; d_done still pulses.
- **Ignored m_done**: m_done is ignored in IDLE, ISSUE, and RESP. This covers a late answer after a timeout.
- **Request handshake**:
  - A requester may change or deassert req/fields in the cycle after it sees done.
  - Dropping req before done is illegal; the arbiter completes the transaction regardless.
- **Reset**: asserting reset at any time forces IDLE. All outputs go to 0, including rdata registers, owner, streak, and timer. No done pulse is produced for an aborted transaction.

## Timing
- **Fastest transaction**: req is sampled in IDLE at cycle 0; m_valid in cycle 1; m_done earliest in cycle 2; done in cycle 3. The next grant is possible in cycle 4 (IDLE in cycle 4).
- **General latency**: with memory answering L cycles after m_valid (L≥1), done occurs L+1 cycles after m_valid.
- **Timeout**: with no m_done, WAIT lasts exactly TIMEOUT cycles; done with err occurs TIMEOUT+1 cycles after m_valid.
- **Pulse widths**: m_valid, i_done, and d_done are each high exactly one cycle per transaction, never simultaneously with each other's requester.
- **Registered outputs**: all outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Single fetch**: i_req=1, i_addr=0x010, memory answers m_rdata=0xDEADBEEF two cycles after m_valid. Expect m_addr=0x010, m_wen=0, m_be=4'hF, and i_done in the cycle after m_done with i_rdata=0xDEADBEEF, i_err=0.
- **Byte write**: d_req=1, d_wen=1, d_addr=0x3FF, d_wdata=0x11223344, d_be=4'b0100. Expect m_valid with those exact fields, then d_done with d_rdata unchanged.
- **Simultaneous requests, STARVE_LIMIT=4**: i_req and d_req held continuously (data re-requesting after every d_done). Expect grant order D,D,D,D,I,D,D,D,D,I.
- **Timeout, TIMEOUT=8**: issue a data read with m_done never asserted. Expect d_done 9 cycles after m_valid with d_err=1 and d_rdata=0. A late m_done afterwards is ignored; state stays IDLE.
- **Reset mid-WAIT**: drop reset for one cycle while in WAIT. Expect busy=0 immediately, no i_done/d_done, and all outputs 0. A following m_done is ignored.
- **Back-to-back fetches**: i_req held high with a new i_addr after each i_done, and the memory answering in 1 cycle. Expect one transaction every 4 cycles.
